// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing, pixel addressing and blanked RGB/sync output
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int COLOR_BITS  = 4
) (
  input  logic                  CLOCK_25,
  input  logic                  RESET_N,
  input  logic [2:0]            color,
  output logic [11:0]           x,
  output logic [11:0]           y,
  output logic                  active,
  output logic                  frame_tick,
  output logic [COLOR_BITS-1:0] VGA_R,
  output logic [COLOR_BITS-1:0] VGA_G,
  output logic [COLOR_BITS-1:0] VGA_B,
  output logic                  HSYNC,
  output logic                  VSYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Stage 0: raster position counters
  logic [9:0] h_q, h_d, v_q, v_d;

  // Stage 1: pixel address and internal (polarity-free) sync flags
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        active_q, active_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d;
  logic        tick_q, tick_d;

  // Stage 2: pin-level video outputs
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;

  // Counter advance: h every clock, v on line wrap, both wrap together at frame end
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // Stage 1 decode of the current counter position
  always_comb begin
    active_d = (h_q < H_ACT) && (v_q < V_ACT);
    x_d      = active_d ? {2'b00, h_q + 10'd1} : 12'd0;
    y_d      = active_d ? {2'b00, v_q + 10'd1} : 12'd0;
    hs1_d    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vs1_d    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    tick_d   = (h_q == 10'd0) && (v_q == V_ACT);
  end

  // Stage 2: blank colour outside the visible area, map syncs to pin polarity
  always_comb begin
    r_d     = active_q ? {COLOR_BITS{color[2]}} : '0;
    g_d     = active_q ? {COLOR_BITS{color[1]}} : '0;
    b_d     = active_q ? {COLOR_BITS{color[0]}} : '0;
    hsync_d = hs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = vs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Stage 0 register; reset restarts the raster at the top-left pixel
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 1 register; reset clears sync flags so no stray pulse reaches the pins
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      tick_q   <= tick_d;
    end
  end

  // Stage 2 register; reset drives black and idle sync levels
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign active     = active_q;
  assign frame_tick = tick_q;
  assign VGA_R      = r_q;
  assign VGA_G      = g_q;
  assign VGA_B      = b_q;
  assign HSYNC      = hsync_q;
  assign VSYNC      = vsync_q;

endmodule
